// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-buffer constants, word type and padded-length helper.
package sha256_pkg;

  localparam int unsigned MSG_MEM_WORDS = 1024;
  localparam int unsigned MSG_MAX_BYTES = 4096;

  typedef logic [31:0] word_t;

  // Padded length in 32-bit words: ceil((len + 9) / 64) blocks of 16 words.
  function automatic logic [10:0] calc_pad_words(input logic [12:0] len);
    logic [13:0] blocks;
    blocks = ({1'b0, len} + 14'd72) >> 6;
    return {blocks[6:0], 4'b0000};
  endfunction

endpackage

// File: rtl/sha_msg_ram.sv
// Simple dual-port message RAM, registered read port, read-before-write.
module sha_msg_ram
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        wr_en,
  input  logic [9:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [9:0]  rd_addr,
  output logic [31:0] rd_data
);

  word_t mem [MSG_MEM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sha_msg_responder.sv
// Serves padded SHA-256 message words to the hash core with fixed 2-cycle latency.
module sha_msg_responder
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [9:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        cfg_vld,
  input  logic [12:0] cfg_len,
  input  logic        mem_addr_vld,
  input  logic [31:0] mem_addr,
  output logic        mem_data_vld,
  output logic [31:0] mem_data,
  output logic [10:0] pad_words,
  output logic        err
);

  logic [12:0] len_q;
  logic        cfg_bad;

  logic        v1;
  logic [29:0] w1;
  logic [12:0] len1;
  logic [10:0] pw1;
  word_t       ram_rd;

  logic        in_range;
  logic        oor;
  logic [12:0] b_idx;
  word_t       pad_word;

  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  assign cfg_bad = cfg_vld && (cfg_len > 13'(MSG_MAX_BYTES));

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      pad_words <= 11'd16;
    end else if (cfg_vld && !cfg_bad) begin
      len_q     <= cfg_len;
      pad_words <= calc_pad_words(cfg_len);
    end
  end

  sha_msg_ram u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (mem_addr[11:2]),
    .rd_data (ram_rd)
  );

  // Stage 1 snapshots L and P/4 so a later cfg_vld cannot affect in-flight requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      w1   <= '0;
      len1 <= '0;
      pw1  <= '0;
    end else begin
      v1 <= mem_addr_vld;
      if (mem_addr_vld) begin
        w1   <= mem_addr[31:2];
        len1 <= len_q;
        pw1  <= pad_words;
      end
    end
  end

  assign in_range = w1 < {19'b0, pw1};
  assign oor      = v1 && !in_range;

  // The length field is only non-zero in the final word, since 8*L never exceeds 16 bits.
  always_comb begin
    pad_word = '0;
    b_idx    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      b_idx = {w1[10:0], k[1:0]};
      if (b_idx < len1)
        pad_word[(3-k)*8 +: 8] = ram_rd[(3-k)*8 +: 8];
      else if (b_idx == len1)
        pad_word[(3-k)*8 +: 8] = 8'h80;
    end
    if (w1[10:0] == pw1 - 11'd1)
      pad_word = {16'b0, len1, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data_vld <= 1'b0;
      mem_data     <= '0;
      err          <= 1'b0;
    end else begin
      mem_data_vld <= v1;
      if (v1)
        mem_data <= in_range ? pad_word : '0;
      err <= err | cfg_bad | oor;
    end
  end

endmodule

// File: tb/tb_sha_msg_responder.sv
// Scoreboard bench for sha_msg_responder against a byte-level padding model.
module tb_sha_msg_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cfg_vld;
  logic [12:0] cfg_len;
  logic        mem_addr_vld;
  logic [31:0] mem_addr;
  logic        mem_data_vld;
  logic [31:0] mem_data;
  logic [10:0] pad_words;
  logic        err;

  always #5 clk = ~clk;

  sha_msg_responder dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cfg_vld      (cfg_vld),
    .cfg_len      (cfg_len),
    .mem_addr_vld (mem_addr_vld),
    .mem_addr     (mem_addr),
    .mem_data_vld (mem_data_vld),
    .mem_data     (mem_data),
    .pad_words    (pad_words),
    .err          (err)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] log_q[$];

  logic [31:0] ram_m [1024];
  int unsigned len_m;
  bit          err_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  function automatic int unsigned padded_bytes(input int unsigned l);
    return ((l + 9 + 63) / 64) * 64;
  endfunction

  // Padded message byte stream: data, 0x80, zeros, 64-bit big-endian bit count.
  function automatic logic [31:0] model_word(input longint unsigned w, input int unsigned l);
    longint unsigned p, b;
    logic [63:0] bits;
    logic [31:0] res;
    logic [31:0] rw;
    logic [7:0]  by;
    p = padded_bytes(l);
    res = '0;
    if (w * 4 >= p) return '0;
    bits = 64'(l) * 64'd8;
    for (int k = 0; k < 4; k++) begin
      b = w * 4 + longint'(k);
      if (b < l) begin
        rw = ram_m[b / 4];
        by = rw[(3 - (b % 4)) * 8 +: 8];
      end else if (b == l) by = 8'h80;
      else if (b >= p - 8) by = bits[(p - 1 - b) * 8 +: 8];
      else by = 8'h00;
      res = {res[23:0], by};
    end
    return res;
  endfunction

  task automatic drive(input bit rv, input logic [31:0] ra, input bit wv, input logic [9:0] wa,
                       input logic [31:0] wd, input bit cv, input logic [12:0] cl);
    exp_t e;
    mem_addr_vld = rv; mem_addr = ra;
    wr_en = wv; wr_addr = wa; wr_data = wd;
    cfg_vld = cv; cfg_len = cl;
    if (rv) begin
      e.data = model_word(longint'(ra[31:2]), len_m);
      e.due  = cyc + 2;
      sbq.push_back(e);
      if (longint'(ra[31:2]) * 4 >= longint'(padded_bytes(len_m))) err_m = 1'b1;
    end
    if (wv) ram_m[wa] = wd;
    if (cv) begin
      if (int'(cl) > 4096) err_m = 1'b1;
      else len_m = cl;
    end
    @(posedge clk); #1;
    mem_addr_vld = 1'b0; wr_en = 1'b0; cfg_vld = 1'b0;
    check("pad_words", 64'(pad_words), 64'(padded_bytes(len_m) / 4));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, '0, '0, 0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0) break;
      idle(1);
    end
    check("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    len_m = 0;
    err_m = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mem_data_vld === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: got data 0x%0h with no request pending at cycle %0d", mem_data, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("resp_data", 64'(mem_data), 64'(e.data));
        check("resp_latency", 64'(cyc), 64'(e.due));
        log_q.push_back(mem_data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cfg_vld = 1'b0; cfg_len = '0; mem_addr_vld = 1'b0; mem_addr = '0;
    len_m = 0; err_m = 1'b0;

    do_reset();
    check("rst_vld", 64'(mem_data_vld), 64'd0);
    check("rst_data", 64'(mem_data), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_pad", 64'(pad_words), 64'd16);

    for (int i = 0; i < 1024; i++) drive(0, '0, 1, 10'(i), $urandom, 0, '0);

    // "abc", 16 back-to-back requests
    drive(0, '0, 1, 10'd0, 32'h61626300, 1, 13'd3);
    log_q.delete();
    for (int w = 0; w < 16; w++) drive(1, 32'(w * 4), 0, '0, '0, 0, '0);
    drain();
    check("abc_count", 64'(log_q.size()), 64'd16);
    check("abc_pad", 64'(pad_words), 64'd16);
    check("abc_w0", 64'(log_q[0]), 64'h61626380);
    for (int w = 1; w < 15; w++) check("abc_zero", 64'(log_q[w]), 64'd0);
    check("abc_w15", 64'(log_q[15]), 64'h18);

    // empty message
    drive(0, '0, 0, '0, '0, 1, 13'd0);
    log_q.delete();
    for (int w = 0; w < 16; w++) drive(1, 32'(w * 4), 0, '0, '0, 0, '0);
    drain();
    check("len0_w0", 64'(log_q[0]), 64'h80000000);
    for (int w = 1; w < 16; w++) check("len0_zero", 64'(log_q[w]), 64'd0);

    // 56 bytes spills into a second block
    drive(0, '0, 0, '0, '0, 1, 13'd56);
    check("len56_pad", 64'(pad_words), 64'd32);
    log_q.delete();
    drive(1, 32'(14 * 4), 0, '0, '0, 0, '0);
    drive(1, 32'(30 * 4), 0, '0, '0, 0, '0);
    drive(1, 32'(31 * 4) | 32'h3, 0, '0, '0, 0, '0);
    drain();
    check("len56_w14", 64'(log_q[0]), 64'h80000000);
    check("len56_w30", 64'(log_q[1]), 64'd0);
    check("len56_w31", 64'(log_q[2]), 64'h1C0);

    // read-before-write on word 0
    drive(0, '0, 1, 10'd0, 32'h11223344, 1, 13'd4);
    log_q.delete();
    drive(1, 32'd0, 1, 10'd0, 32'hDEADBEEF, 0, '0);
    drive(1, 32'd0, 0, '0, '0, 0, '0);
    drain();
    check("rbw_old", 64'(log_q[0]), 64'h11223344);
    check("rbw_new", 64'(log_q[1]), 64'hDEADBEEF);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rv, wv, cv;
      logic [31:0] ra;
      rv = ($urandom_range(0, 3) != 0);
      wv = ($urandom_range(0, 2) == 0);
      cv = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) ra = $urandom;
      else ra = 32'($urandom_range(0, padded_bytes(len_m) / 4 + 3) * 4 + $urandom_range(0, 3));
      drive(rv, ra, wv, 10'($urandom), $urandom, cv, 13'($urandom_range(0, 4200)));
    end
    drain();
    check("rand_err", 64'(err), 64'(err_m));

    // out-of-range request and illegal length
    do_reset();
    check("err_clear", 64'(err), 64'd0);
    drive(0, '0, 0, '0, '0, 1, 13'd3);
    log_q.delete();
    drive(1, 32'h200, 0, '0, '0, 0, '0);
    drain();
    check("oor_data", 64'(log_q[0]), 64'd0);
    check("oor_err", 64'(err), 64'd1);
    idle(100);
    check("oor_err_sticky", 64'(err), 64'd1);
    drive(0, '0, 0, '0, '0, 1, 13'd5000);
    check("bad_len_pad", 64'(pad_words), 64'd16);
    drive(1, 32'd0, 0, '0, '0, 0, '0);
    drain();
    check("bad_len_err", 64'(err), 64'd1);

    // reset one cycle after a request
    drive(1, 32'd0, 0, '0, '0, 0, '0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("no_vld_after_rst", 64'(mem_data_vld), 64'd0);
      idle(1);
    end
    check("post_rst_err", 64'(err), 64'd0);
    drive(0, '0, 0, '0, '0, 1, 13'd3);
    drive(1, 32'd0, 0, '0, '0, 0, '0);
    drive(1, 32'd60, 0, '0, '0, 0, '0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
